// File: rtl/uart_tx_serializer_if.sv
// rtl/uart_tx_serializer_if.sv - byte-request / serial-line bundle for the UART transmitter
//
// Groups the transmit handshake and line outputs so producer and transmitter
// connect through a single port.
//   Tx_DV_in       producer -> tx  one-cycle request, byte valid this cycle
//   Tx_Byte_in     producer -> tx  byte to send, sampled only on acceptance
//   Tx_Serial_out  tx -> line      UART line, idles high
//   Tx_Active_out  tx -> producer  high while a frame is on the line
//   Tx_Done_out    tx -> producer  one-cycle pulse after the stop bit
interface uart_tx_serializer_if;
    logic       Tx_DV_in;
    logic [7:0] Tx_Byte_in;
    logic       Tx_Serial_out;
    logic       Tx_Active_out;
    logic       Tx_Done_out;

    modport master (
        output Tx_DV_in,
        output Tx_Byte_in,
        input  Tx_Serial_out,
        input  Tx_Active_out,
        input  Tx_Done_out
    );

    modport slave (
        input  Tx_DV_in,
        input  Tx_Byte_in,
        output Tx_Serial_out,
        output Tx_Active_out,
        output Tx_Done_out
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - 8N1 UART transmitter with registered outputs
//
// Serialises one byte per accepted request: start bit (low), 8 data bits LSB
// first, stop bit (high). Each bit lasts CLKS_PER_BIT clock cycles, so a frame
// occupies exactly 10*CLKS_PER_BIT cycles on the line, followed by a single
// CLEANUP cycle that carries the Done pulse.
//
// Ports:
//   CLK  system clock, rising edge
//   RST  asynchronous active-low reset; forces the line high at once
//   tx   slave side of uart_tx_serializer_if (request in, line/status out)
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per bit period, 2..65535
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                   CLK,
    input  logic                   RST,
    uart_tx_serializer_if.slave    tx
);

    // Counter only needs to reach CLKS_PER_BIT-1; keep at least one bit.
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_CLEANUP
    } state_t;

    state_t           state_q,   state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q,   shift_d;
    logic             serial_q,  serial_d;
    logic             active_q,  active_d;
    logic             done_q,    done_d;

    logic             bit_end;

    // Last cycle of the current bit period.
    assign bit_end = (clk_cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        serial_d  = serial_q;
        active_d  = active_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                serial_d  = 1'b1;
                active_d  = 1'b0;
                clk_cnt_d = '0;
                bit_idx_d = '0;
                if (tx.Tx_DV_in) begin
                    // Latch the byte here so later input changes cannot
                    // disturb the frame in flight.
                    shift_d  = tx.Tx_Byte_in;
                    state_d  = S_START;
                    serial_d = 1'b0;
                    active_d = 1'b1;
                end
            end

            S_START: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = S_DATA;
                    serial_d  = shift_q[0];
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_ONE;
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d  = S_STOP;
                        serial_d = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        // Present the next bit on the same edge that ends
                        // the current one so each bit is a full period.
                        serial_d  = shift_q[bit_idx_q + 3'd1];
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_ONE;
                end
            end

            S_STOP: begin
                serial_d = 1'b1;
                if (bit_end) begin
                    clk_cnt_d = '0;
                    state_d   = S_CLEANUP;
                    done_d    = 1'b1;
                    active_d  = 1'b0;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_ONE;
                end
            end

            S_CLEANUP: begin
                // Single cycle holding Done; the following edge returns to
                // IDLE where a new request is accepted immediately.
                serial_d = 1'b1;
                active_d = 1'b0;
                state_d  = S_IDLE;
            end

            default: begin
                state_d   = S_IDLE;
                serial_d  = 1'b1;
                active_d  = 1'b0;
                clk_cnt_d = '0;
                bit_idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            serial_q  <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            serial_q  <= serial_d;
            active_q  <= active_d;
            done_q    <= done_d;
        end
    end

    assign tx.Tx_Serial_out = serial_q;
    assign tx.Tx_Active_out = active_q;
    assign tx.Tx_Done_out   = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - scoreboard bench for uart_tx_serializer
module tb_uart_tx_serializer;

    localparam int CPB = 4;

    logic clk;
    logic rst_n;

    uart_tx_serializer_if bus_a ();
    uart_tx_serializer_if bus_b ();

    uart_tx_serializer #(.CLKS_PER_BIT(CPB)) u_dut_a (
        .CLK (clk),
        .RST (rst_n),
        .tx  (bus_a)
    );

    uart_tx_serializer u_dut_b (
        .CLK (clk),
        .RST (rst_n),
        .tx  (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    int         done_times[$];

    task automatic check(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor for DUT A: decodes the line at mid-bit and scores each frame
    // against the expected queue when the Done pulse appears.
    int         cyc = 0;
    int         start_cyc = 0;
    int         off;
    bit         in_frame = 1'b0;
    logic       prev_line = 1'b1;
    logic       prev_done = 1'b0;
    logic [7:0] dec = '0;
    logic [7:0] e;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                in_frame  = 1'b0;
                prev_line = 1'b1;
                prev_done = 1'b0;
            end else begin
                if (prev_done)
                    check(bus_a.Tx_Done_out == 1'b0, "done_width", int'(bus_a.Tx_Done_out), 0);
                if (bus_a.Tx_Done_out && !prev_done) begin
                    done_times.push_back(cyc);
                    check(bus_a.Tx_Active_out == 1'b0, "active_at_done", int'(bus_a.Tx_Active_out), 0);
                    if (exp_q.size() == 0) begin
                        check(1'b0, "unexpected_done", cyc, -1);
                    end else begin
                        e = exp_q.pop_front();
                        check(dec == e, "frame_byte", int'(dec), int'(e));
                        check(cyc - start_cyc == 10 * CPB, "done_latency", cyc - start_cyc, 10 * CPB);
                    end
                end
                if (!in_frame && prev_line && !bus_a.Tx_Serial_out) begin
                    in_frame  = 1'b1;
                    start_cyc = cyc;
                end
                if (in_frame) begin
                    off = cyc - start_cyc;
                    if (off % CPB == CPB / 2) begin
                        check(bus_a.Tx_Active_out == 1'b1, "active_mid_bit", int'(bus_a.Tx_Active_out), 1);
                        if (off / CPB == 0) begin
                            check(bus_a.Tx_Serial_out == 1'b0, "start_bit", int'(bus_a.Tx_Serial_out), 0);
                        end else if (off / CPB <= 8) begin
                            dec[off / CPB - 1] = bus_a.Tx_Serial_out;
                        end else begin
                            check(bus_a.Tx_Serial_out == 1'b1, "stop_bit", int'(bus_a.Tx_Serial_out), 1);
                            in_frame = 1'b0;
                        end
                    end
                end
                prev_line = bus_a.Tx_Serial_out;
                prev_done = bus_a.Tx_Done_out;
            end
        end
    end

    // Presents a request in one cycle; the second rising edge is the accept edge.
    task automatic send_a(input logic [7:0] b, input bit expect_frame);
        @(posedge clk);
        #1;
        bus_a.Tx_DV_in   = 1'b1;
        bus_a.Tx_Byte_in = b;
        if (expect_frame)
            exp_q.push_back(b);
        @(posedge clk);
        #1;
        bus_a.Tx_DV_in = 1'b0;
        if (expect_frame) begin
            check(bus_a.Tx_Serial_out == 1'b0, "line_low_after_accept", int'(bus_a.Tx_Serial_out), 0);
            check(bus_a.Tx_Active_out == 1'b1, "active_after_accept", int'(bus_a.Tx_Active_out), 1);
        end
    endtask

    task automatic wait_done_a(input int limit, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus_a.Tx_Done_out) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen)
            check(1'b0, name, 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    int low_cnt;
    int done_at;
    int hi_at_bit7;

    initial begin
        rst_n            = 1'b0;
        bus_a.Tx_DV_in   = 1'b0;
        bus_a.Tx_Byte_in = 8'h00;
        bus_b.Tx_DV_in   = 1'b0;
        bus_b.Tx_Byte_in = 8'h00;

        // 1: reset hold and idle after release
        repeat (5) begin
            @(negedge clk);
            check(bus_a.Tx_Serial_out == 1'b1, "rst_line", int'(bus_a.Tx_Serial_out), 1);
            check(bus_a.Tx_Active_out == 1'b0, "rst_active", int'(bus_a.Tx_Active_out), 0);
            check(bus_a.Tx_Done_out == 1'b0, "rst_done", int'(bus_a.Tx_Done_out), 0);
        end
        check(bus_b.Tx_Serial_out == 1'b1, "rst_line_b", int'(bus_b.Tx_Serial_out), 1);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check(bus_a.Tx_Serial_out == 1'b1, "idle_line", int'(bus_a.Tx_Serial_out), 1);
            check(bus_a.Tx_Active_out == 1'b0, "idle_active", int'(bus_a.Tx_Active_out), 0);
        end

        // 2: single frame 0x12
        send_a(8'h12, 1'b1);
        wait_done_a(60, "timeout_0x12");
        repeat (4) @(posedge clk);

        // 3: 0xFF then 0x80 in the first IDLE cycle after Done
        send_a(8'hFF, 1'b1);
        wait_done_a(60, "timeout_0xFF");
        send_a(8'h80, 1'b1);
        wait_done_a(60, "timeout_0x80");
        repeat (4) @(posedge clk);

        // 4: request mid-frame is dropped, byte change has no effect
        send_a(8'h34, 1'b1);
        repeat (19) @(posedge clk);
        #1;
        bus_a.Tx_DV_in   = 1'b1;
        bus_a.Tx_Byte_in = 8'hAA;
        @(posedge clk);
        #1;
        bus_a.Tx_DV_in   = 1'b0;
        bus_a.Tx_Byte_in = 8'h00;
        wait_done_a(60, "timeout_0x34");
        repeat (60) @(posedge clk);

        // 5: reset mid-frame, then a clean frame
        send_a(8'h55, 1'b1);
        repeat (15) @(posedge clk);
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check(bus_a.Tx_Serial_out == 1'b1, "midrst_line", int'(bus_a.Tx_Serial_out), 1);
        check(bus_a.Tx_Active_out == 1'b0, "midrst_active", int'(bus_a.Tx_Active_out), 0);
        check(bus_a.Tx_Done_out == 1'b0, "midrst_done", int'(bus_a.Tx_Done_out), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(posedge clk);
        send_a(8'h0F, 1'b1);
        wait_done_a(60, "timeout_0x0F");
        repeat (10) @(posedge clk);

        check(done_times.size() == 5, "done_count", done_times.size(), 5);
        if (done_times.size() >= 3)
            check(done_times[2] - done_times[1] == 42, "b2b_spacing", done_times[2] - done_times[1], 42);
        check(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 0);

        // 6: default CLKS_PER_BIT=868, byte 0x80
        @(posedge clk);
        #1;
        bus_b.Tx_DV_in   = 1'b1;
        bus_b.Tx_Byte_in = 8'h80;
        @(posedge clk);
        #1;
        bus_b.Tx_DV_in = 1'b0;
        check(bus_b.Tx_Serial_out == 1'b0, "b_line_low", int'(bus_b.Tx_Serial_out), 0);
        low_cnt    = 0;
        done_at    = -1;
        hi_at_bit7 = 0;
        for (int i = 0; i < 9000; i++) begin
            @(negedge clk);
            if (bus_b.Tx_Serial_out == 1'b0)
                low_cnt++;
            if (i == 8 * 868)
                hi_at_bit7 = int'(bus_b.Tx_Serial_out);
            if (bus_b.Tx_Done_out) begin
                done_at = i;
                break;
            end
        end
        // Start bit plus seven zero data bits precede the single one bit.
        check(low_cnt == 8 * 868, "b_low_run", low_cnt, 8 * 868);
        check(hi_at_bit7 == 1, "b_bit7", hi_at_bit7, 1);
        check(done_at == 8680, "b_done_latency", done_at, 8680);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- UART transmitter directly downstream of the Core block.
- Accepts one byte per Tx_DV_in pulse and serialises it as 8N1: one start bit, 8 data bits LSB first, one stop bit, no parity.
- Pulses Tx_Done_out for one cycle at the end of each frame; Core uses this pulse to release its next result byte.
- Top-level instantiation pairs it with the UART receiver feeding Core's Rx_Byte_in/Rx_DV_in.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per bit period (100 MHz / 115200 baud). Legal range 2..65535.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-low reset.
- Tx_DV_in  input  1  one-cycle request; byte on Tx_Byte_in is valid this cycle.
- Tx_Byte_in  input  8  byte to transmit; sampled only when accepted.
- Tx_Serial_out  output  1  UART line; idles high.
- Tx_Active_out  output  1  high while a frame is on the line.
- Tx_Done_out  output  1  one-cycle pulse after the stop bit completes.

Behaviour:
- All outputs are registered.
- Reset (RST low, asynchronous): state IDLE, Tx_Serial_out=1, Tx_Active_out=0, Tx_Done_out=0, bit counter=0, clock counter=0, shift register=0.
- States: IDLE, START, DATA, STOP, CLEANUP.
- IDLE:
  - Tx_Serial_out=1.
  - When Tx_DV_in=1 at edge k: latch Tx_Byte_in, enter START. After edge k, Tx_Serial_out=0 and Tx_Active_out=1.
- START:
  - Holds the line low for CLKS_PER_BIT cycles.
  - Clock counter counts 0..CLKS_PER_BIT-1, then resets to 0 and the block enters DATA with bit index 0.
- DATA:
  - Drives latched bit[index] for CLKS_PER_BIT cycles per bit.
  - Bit index 0..7 increments at the end of each bit period.
  - After bit 7 the block enters STOP.
- STOP:
  - Line high for CLKS_PER_BIT cycles.
  - At the edge ending the stop bit: enter CLEANUP, Tx_Done_out=1, Tx_Active_out=0.
- CLEANUP:
  - Lasts exactly one cycle with Tx_Done_out=1 and the line high.
  - Next edge: IDLE, Tx_Done_out=0.
- Timing:
  - Frame length on the line is exactly 10*CLKS_PER_BIT cycles.
  - Start bit begins 1 cycle after the accepting edge.
  - Tx_Done_out rises 10*CLKS_PER_BIT cycles after the first start-bit cycle begins.
- Acceptance and data stability:
  - Tx_DV_in is accepted only in IDLE.
  - Requests in START/DATA/STOP/CLEANUP are ignored and not queued.
  - Tx_Byte_in changes after acceptance have no effect on the frame in flight.
- Back-to-back: a request in the first IDLE cycle after CLEANUP is accepted. The minimum DV-to-DV spacing is 10*CLKS_PER_BIT+2 cycles.
- Reset mid-frame:
  - Line returns high immediately (asynchronously) and the frame is abandoned.
  - No Tx_Done_out pulse is produced.
  - After release the block is in IDLE.
- Counters:
  - Clock counter width is clog2(CLKS_PER_BIT), minimum 1.
  - Bit index is 3 bits; no wrap beyond 7 is reachable.
- No glitches on Tx_Serial_out: it changes only on clock edges or on asynchronous reset assertion.

Test Plan:
All cases use CLKS_PER_BIT=4, 10 ns clock, and DV accepted at edge k.
1. Reset hold for 5 cycles, then release, no DV → Tx_Serial_out=1, Tx_Active_out=0, Tx_Done_out=0 throughout.
2. Send 0x12 → line sampled mid-bit reads 0 (start), then 0,1,0,0,1,0,0,0, then 1 (stop). Tx_Done_out is high for exactly one cycle, after edge k+41. Tx_Active_out is high from k+1 through k+40.
3. Send 0xFF, then 0x80 in the first IDLE cycle after Done → two complete frames. Decoded bytes are 0xFF and 0x80; there are exactly 2 Done pulses 42 cycles apart.
4. Send 0x34, then pulse DV with 0xAA at k+20 and change Tx_Byte_in to 0x00 at k+21 → the frame decodes as 0x34 and the 0xAA request is dropped; only one Done pulse.
5. Send 0x55, assert RST at k+15 for 3 cycles → line high immediately on RST assertion, Tx_Active_out=0, no Done pulse. A subsequent send of 0x0F decodes correctly.
6. Default CLKS_PER_BIT=868, send 0x80 → start-bit low for exactly 868 cycles; Done arrives 8680 cycles after the start-bit edge.
